// File: rtl/burst_grant_arbiter.sv
// burst_grant_arbiter
// Round-robin arbiter that hands a shared resource to one requester for an
// uninterrupted window of BURST_LEN cycles. The owner must keep its request
// high for the whole window; dropping it early aborts the burst. Completed
// and aborted bursts are reported with one-cycle pulses, and at least one idle
// cycle always separates two bursts.
// Optional embedded properties: define BURST_GRANT_ARBITER_SVA_EN.

module burst_grant_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 5,
    localparam int OW = (NUM_REQ   > 1) ? $clog2(NUM_REQ)   : 1,
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OW-1:0]      owner,
    output logic               busy,
    output logic               burst_done,
    output logic               burst_abort
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [OW-1:0] OWNER_ONE  = OW'(1);
    localparam logic [OW-1:0] OWNER_LAST = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BURST_LEN - 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        ptr_q,   ptr_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 abort_q, abort_d;

    logic                 found_s;
    logic [OW-1:0]        winner_s;
    logic [OW-1:0]        idx_s;
    logic [OW-1:0]        next_ptr_s;

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin search: first set request at ptr, ptr+1, ... wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {OW{1'b0}};
        idx_s    = {OW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = OW'((int'(ptr_q) + i) % NUM_REQ);
            if (req[idx_s] && !found_s) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                // an earlier hit (or no request here) keeps the current winner
                winner_s = winner_s;
            end
        end
    end

    // Pointer moves just past the finishing owner, wrapping at the top index.
    always_comb begin
        if (owner_q == OWNER_LAST) begin
            next_ptr_s = {OW{1'b0}};
        end else begin
            next_ptr_s = owner_q + OWNER_ONE;
        end
    end

    // Next-state and output logic; abort takes priority over completion.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_d   = onehot(winner_s);
                    owner_d = winner_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_GRANT;
                end else begin
                    gnt_d   = {NUM_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    gnt_d   = {NUM_REQ{1'b0}};
                    abort_d = 1'b1;
                    ptr_d   = next_ptr_s;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    gnt_d   = {NUM_REQ{1'b0}};
                    done_d  = 1'b1;
                    ptr_d   = next_ptr_s;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                gnt_d   = {NUM_REQ{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    // State and registered outputs; asynchronous clear on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= {NUM_REQ{1'b0}};
            owner_q <= {OW{1'b0}};
            ptr_q   <= {OW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign burst_done  = done_q;
    assign burst_abort = abort_q;

`ifdef BURST_GRANT_ARBITER_SVA_EN
    default clocking cb @(posedge clk); endclocking
    default disable iff (!rst_n);

    a_gnt_onehot0: assert property ($onehot0(gnt_q));

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_drop
        a_drop_aborts: assert property (gnt_q[g] && !req[g] |=> abort_q);
    end

    a_done_len: assert property (done_q |->
        $past(gnt_q != {NUM_REQ{1'b0}}, 1) &&
        ($past(gnt_q, BURST_LEN) == $past(gnt_q, 1)));

    a_no_both: assert property (!(done_q && abort_q));

    c_full_burst: cover property (gnt_q[0] [*BURST_LEN] ##1 done_q);
    c_abort:      cover property (abort_q);
`else
    // Properties compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_burst_grant_arbiter.sv
// Directed bench for burst_grant_arbiter: a vector table for the default
// build (4 requesters, 5-cycle bursts) plus hand sequences for reset in the
// middle of a burst and a second instance built with BURST_LEN=1.

module tb_burst_grant_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       abort_a, abort_b;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       done;
        logic       abort;
    } vec_t;

    vec_t vecs[$];

    burst_grant_arbiter #(.NUM_REQ(4), .BURST_LEN(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .owner(owner_a),
        .busy(busy_a), .burst_done(done_a), .burst_abort(abort_a)
    );

    burst_grant_arbiter #(.NUM_REQ(4), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .owner(owner_b),
        .busy(busy_b), .burst_done(done_b), .burst_abort(abort_b)
    );

    // 10-unit clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] oh4(input int k);
        logic [3:0] v;
        v = 4'b0001;
        return v << k;
    endfunction

    function automatic void add(input logic [3:0] r, input logic [3:0] g,
                                input int o, input logic b, input logic d,
                                input logic a);
        vec_t v;
        v.req = r; v.gnt = g; v.owner = 2'(o); v.busy = b; v.done = d; v.abort = a;
        vecs.push_back(v);
    endfunction

    // Compare {gnt, owner, busy, done, abort} against the expected pack.
    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got gnt/own/busy/done/abort=%b_%b_%b%b%b expected %b_%b_%b%b%b",
                     name, act[8:5], act[4:3], act[2], act[1], act[0],
                     exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [8:0] pack(input logic [3:0] g, input int o,
                                        input logic b, input logic d, input logic a);
        return {g, 2'(o), b, d, a};
    endfunction

    task automatic step_check_a(input string name, input logic [3:0] r, input logic [3:0] g,
                                input int o, input logic b, input logic d, input logic a);
        req_a = r;
        @(posedge clk);
        #1;
        check(name, {gnt_a, owner_a, busy_a, done_a, abort_a}, pack(g, o, b, d, a));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_a    = 4'b0000;
        req_b    = 4'b0000;

        // Fairness from ptr=0: owners 0,1,2,3 each for 5 cycles plus done.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) add(4'b1111, oh4(k), k, 1'b1, 1'b0, 1'b0);
            add(4'b1111, 4'b0000, k, 1'b0, 1'b1, 1'b0);
        end
        add(4'b1111, 4'b0001, 0, 1'b1, 1'b0, 1'b0);   // wraps to 0
        add(4'b1110, 4'b0000, 0, 1'b0, 1'b0, 1'b1);   // owner drops: abort
        add(4'b0000, 4'b0000, 0, 1'b0, 1'b0, 1'b0);   // idle, owner held
        // req[2] alone for 3 grant cycles, then dropped; req[3] wins next.
        for (int c = 0; c < 3; c++) add(4'b0100, 4'b0100, 2, 1'b1, 1'b0, 1'b0);
        add(4'b1000, 4'b0000, 2, 1'b0, 1'b0, 1'b1);
        add(4'b1000, 4'b1000, 3, 1'b1, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 3, 1'b0, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 3, 1'b0, 1'b0, 1'b0);
        // req[2] aborted with nothing else pending: grant wraps back to 2.
        add(4'b0100, 4'b0100, 2, 1'b1, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 2, 1'b0, 1'b0, 1'b1);
        // Boundary collision: drop on the edge where cnt reaches its last value.
        for (int c = 0; c < 5; c++) add(4'b0100, 4'b0100, 2, 1'b1, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 2, 1'b0, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2, 1'b0, 1'b0, 1'b0);
        // Single requester through a full burst, idle gap, then regrant.
        for (int c = 0; c < 5; c++) add(4'b0010, 4'b0010, 1, 1'b1, 1'b0, 1'b0);
        add(4'b0010, 4'b0000, 1, 1'b0, 1'b1, 1'b0);
        add(4'b0010, 4'b0010, 1, 1'b1, 1'b0, 1'b0);
        add(4'b0000, 4'b0000, 1, 1'b0, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 1, 1'b0, 1'b0, 1'b0);

        // Reset state (an edge has passed with rst_n low).
        #12;
        check("reset_a", {gnt_a, owner_a, busy_a, done_a, abort_a}, 9'b0000_00_000);
        check("reset_b", {gnt_b, owner_b, busy_b, done_b, abort_b}, 9'b0000_00_000);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step_check_a($sformatf("vec%0d", i), vecs[i].req, vecs[i].gnt,
                         int'(vecs[i].owner), vecs[i].busy, vecs[i].done, vecs[i].abort);
        end

        // Reset mid-burst: ptr is 2 here, req[3] is granted for 3 cycles.
        step_check_a("mid_g1", 4'b1000, 4'b1000, 3, 1'b1, 1'b0, 1'b0);
        step_check_a("mid_g2", 4'b1000, 4'b1000, 3, 1'b1, 1'b0, 1'b0);
        step_check_a("mid_g3", 4'b1000, 4'b1000, 3, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_async_clear", {gnt_a, owner_a, busy_a, done_a, abort_a}, 9'b0000_00_000);
        #2;
        req_a = 4'b1001;
        rst_n = 1'b1;
        // ptr back at 0, so index 0 wins over 3.
        step_check_a("post_rst_ptr0", 4'b1001, 4'b0001, 0, 1'b1, 1'b0, 1'b0);
        step_check_a("post_rst_abort", 4'b1000, 4'b0000, 0, 1'b0, 1'b0, 1'b1);
        step_check_a("post_rst_req3", 4'b1000, 4'b1000, 3, 1'b1, 1'b0, 1'b0);
        req_a = 4'b0000;

        // BURST_LEN=1 instance: grant, done+idle, alternating 0 and 1.
        req_b = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i % 2 == 0) begin
                check($sformatf("b1_grant%0d", i), {gnt_b, owner_b, busy_b, done_b, abort_b},
                      pack(oh4((i / 2) % 2), (i / 2) % 2, 1'b1, 1'b0, 1'b0));
            end else begin
                check($sformatf("b1_done%0d", i), {gnt_b, owner_b, busy_b, done_b, abort_b},
                      pack(4'b0000, (i / 2) % 2, 1'b0, 1'b1, 1'b0));
            end
        end
        req_b = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
